// File: rtl/instr_encoder_loader_if.sv
// rtl/instr_encoder_loader_if.sv - descriptor stream and instruction-memory write bus
interface instr_encoder_loader_if #(
    parameter int ADDR_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [4:0]        op_code;
    logic [4:0]        rd;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [12:0]       imm;
    logic              last;
    logic              im_wen;
    logic [ADDR_W-1:0] im_addr;
    logic [31:0]       im_wdata;

    modport master (
        output in_valid, op_code, rd, rs1, rs2, imm, last,
        input  in_ready, im_wen, im_addr, im_wdata
    );

    modport slave (
        input  in_valid, op_code, rd, rs1, rs2, imm, last,
        output in_ready, im_wen, im_addr, im_wdata
    );
endinterface

// File: rtl/instr_encoder_loader.sv
// rtl/instr_encoder_loader.sv - encodes RV32I descriptors and loads them into instruction memory
module instr_encoder_loader #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256,
    parameter int BASE   = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    instr_encoder_loader_if.slave     bus,
    output logic                      busy,
    output logic                      done,
    output logic                      err,
    output logic [ADDR_W:0]           count
);
    localparam logic [6:0]        OPC_R    = 7'b0110011;
    localparam logic [6:0]        OPC_I    = 7'b0010011;
    localparam logic [6:0]        OPC_LW   = 7'b0000011;
    localparam logic [6:0]        OPC_SW   = 7'b0100011;
    localparam logic [6:0]        OPC_BEQ  = 7'b1100011;
    localparam logic [31:0]       NOP      = 32'h0000_0013;
    localparam logic [ADDR_W+1:0] DEPTH_L  = (ADDR_W+2)'(DEPTH);
    localparam logic [ADDR_W-1:0] BASE_L   = ADDR_W'(BASE);

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

    state_t            state;
    logic              wen_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;

    logic [4:0]        rd, rs1, rs2;
    logic [12:0]       imm;
    logic [ADDR_W+1:0] fill;
    logic              ready_c;
    logic              accept;
    logic [31:0]       enc_word;
    logic              enc_bad;

    assign rd  = bus.rd;
    assign rs1 = bus.rs1;
    assign rs2 = bus.rs2;
    assign imm = bus.imm;

    // fill counts the word still in flight so the DEPTH limit is never overrun
    assign fill    = {1'b0, count} + {{(ADDR_W+1){1'b0}}, wen_q};
    assign ready_c = (state == LOAD) && (fill < DEPTH_L);
    assign accept  = bus.in_valid && ready_c;

    always_comb begin
        enc_word = NOP;
        enc_bad  = 1'b0;
        case (bus.op_code)
            5'd0:  enc_word = {7'h00, rs2, rs1, 3'b000, rd, OPC_R};
            5'd1:  enc_word = {7'h20, rs2, rs1, 3'b000, rd, OPC_R};
            5'd2:  enc_word = {7'h00, rs2, rs1, 3'b001, rd, OPC_R};
            5'd3:  enc_word = {7'h00, rs2, rs1, 3'b010, rd, OPC_R};
            5'd4:  enc_word = {7'h00, rs2, rs1, 3'b011, rd, OPC_R};
            5'd5:  enc_word = {7'h00, rs2, rs1, 3'b100, rd, OPC_R};
            5'd6:  enc_word = {7'h00, rs2, rs1, 3'b101, rd, OPC_R};
            5'd7:  enc_word = {7'h20, rs2, rs1, 3'b101, rd, OPC_R};
            5'd8:  enc_word = {7'h00, rs2, rs1, 3'b110, rd, OPC_R};
            5'd9:  enc_word = {7'h00, rs2, rs1, 3'b111, rd, OPC_R};
            5'd10: enc_word = {imm[11:0], rs1, 3'b000, rd, OPC_I};
            5'd11: enc_word = {imm[11:0], rs1, 3'b010, rd, OPC_I};
            5'd12: enc_word = {imm[11:0], rs1, 3'b011, rd, OPC_I};
            5'd13: enc_word = {imm[11:0], rs1, 3'b100, rd, OPC_I};
            5'd14: enc_word = {imm[11:0], rs1, 3'b110, rd, OPC_I};
            5'd15: enc_word = {imm[11:0], rs1, 3'b111, rd, OPC_I};
            5'd16: enc_word = {7'h00, imm[4:0], rs1, 3'b001, rd, OPC_I};
            5'd17: enc_word = {7'h00, imm[4:0], rs1, 3'b101, rd, OPC_I};
            5'd18: enc_word = {7'h20, imm[4:0], rs1, 3'b101, rd, OPC_I};
            5'd19: enc_word = {imm[11:0], rs1, 3'b010, rd, OPC_LW};
            5'd20: enc_word = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], OPC_SW};
            5'd21: enc_word = {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], OPC_BEQ};
            default: begin
                enc_word = NOP;
                enc_bad  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            wen_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            count   <= '0;
            err     <= 1'b0;
        end else begin
            wen_q <= accept;
            if (accept) begin
                wdata_q <= enc_word;
                if (enc_bad) err <= 1'b1;
            end
            if (wen_q) begin
                addr_q <= addr_q + 1'b1;
                count  <= count + 1'b1;
            end
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state  <= LOAD;
                        count  <= '0;
                        err    <= 1'b0;
                        addr_q <= BASE_L;
                    end
                end
                LOAD: begin
                    if (accept && bus.last) begin
                        state <= DRAIN;
                    end else if (wen_q && fill == DEPTH_L) begin
                        // capacity exhausted before the program ended
                        state <= DONE;
                        err   <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (wen_q) state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready = ready_c;
    assign bus.im_wen   = wen_q;
    assign bus.im_addr  = addr_q;
    assign bus.im_wdata = wdata_q;
    assign busy         = (state == LOAD) || (state == DRAIN);
    assign done         = (state == DONE);
endmodule

// File: tb/tb_instr_encoder_loader.sv
// tb/tb_instr_encoder_loader.sv - directed self-checking bench for instr_encoder_loader
module tb_instr_encoder_loader;
    logic        clk = 1'b0;
    logic        rst_n, start, s_start;
    logic        busy, done, err;
    logic        s_busy, s_done, s_err;
    logic [8:0]  count;
    logic [3:0]  s_count;
    int          checks = 0;
    int          errors = 0;

    logic [7:0]  wa[$];
    logic [31:0] wd[$];
    logic [2:0]  sa[$];
    logic [31:0] sd[$];

    always #5 clk = ~clk;

    instr_encoder_loader_if #(.ADDR_W(8)) m ();
    instr_encoder_loader_if #(.ADDR_W(3)) s ();

    instr_encoder_loader #(.ADDR_W(8), .DEPTH(256), .BASE(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .bus(m),
        .busy(busy), .done(done), .err(err), .count(count)
    );

    instr_encoder_loader #(.ADDR_W(3), .DEPTH(4), .BASE(6)) dut_small (
        .clk(clk), .rst_n(rst_n), .start(s_start), .bus(s),
        .busy(s_busy), .done(s_done), .err(s_err), .count(s_count)
    );

    always @(negedge clk) begin
        if (m.im_wen === 1'b1) begin
            wa.push_back(m.im_addr);
            wd.push_back(m.im_wdata);
        end
        if (s.im_wen === 1'b1) begin
            sa.push_back(s.im_addr);
            sd.push_back(s.im_wdata);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [4:0] op, input logic [4:0] r_d, input logic [4:0] r_s1,
                        input logic [4:0] r_s2, input logic [12:0] im, input logic lst);
        int n = 0;
        m.op_code  = op;
        m.rd       = r_d;
        m.rs1      = r_s1;
        m.rs2      = r_s2;
        m.imm      = im;
        m.last     = lst;
        m.in_valid = 1'b1;
        while (m.in_ready !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk("send_ready", 32'(m.in_ready), 32'd1);
        step();
        m.in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        logic [31:0] addi_k [1:5];
        logic        rdy;
        int          acc;
        int          k;
        int          n0;
        addi_k[1] = 32'h0010_0093;
        addi_k[2] = 32'h0020_0113;
        addi_k[3] = 32'h0030_0193;
        addi_k[4] = 32'h0040_0213;
        addi_k[5] = 32'h0050_0293;

        rst_n = 1'b0; start = 1'b0; s_start = 1'b0;
        m.in_valid = 1'b0; m.op_code = '0; m.rd = '0; m.rs1 = '0; m.rs2 = '0; m.imm = '0; m.last = 1'b0;
        s.in_valid = 1'b0; s.op_code = '0; s.rd = '0; s.rs1 = '0; s.rs2 = '0; s.imm = '0; s.last = 1'b0;
        step();
        step();

        chk("rst_busy",     32'(busy),       32'd0);
        chk("rst_done",     32'(done),       32'd0);
        chk("rst_err",      32'(err),        32'd0);
        chk("rst_count",    32'(count),      32'd0);
        chk("rst_wen",      32'(m.im_wen),   32'd0);
        chk("rst_addr",     32'(m.im_addr),  32'd0);
        chk("rst_wdata",    m.im_wdata,      32'd0);
        chk("rst_ready",    32'(m.in_ready), 32'd0);
        chk("rst_s_done",   32'(s_done),     32'd0);
        chk("rst_s_count",  32'(s_count),    32'd0);

        rst_n = 1'b1;
        step();

        // R-type and shift-immediate, back to back
        pulse_start();
        chk("start_busy", 32'(busy), 32'd1);
        send(5'd0, 5'd3, 5'd1, 5'd2, 13'd0, 1'b0);
        chk("add_wen",   32'(m.im_wen),  32'd1);
        chk("add_addr",  32'(m.im_addr), 32'd16);
        chk("add_data",  m.im_wdata,     32'h0020_81B3);
        send(5'd1, 5'd3, 5'd1, 5'd2, 13'd0, 1'b0);
        chk("sub_addr",  32'(m.im_addr), 32'd17);
        chk("sub_data",  m.im_wdata,     32'h4020_81B3);
        chk("sub_count", 32'(count),     32'd1);
        send(5'd18, 5'd7, 5'd1, 5'd0, 13'd3, 1'b1);
        chk("srai_addr", 32'(m.im_addr), 32'd18);
        chk("srai_data", m.im_wdata,     32'h4030_D393);
        chk("srai_done", 32'(done),      32'd0);
        step();
        chk("t1_done",   32'(done),      32'd1);
        chk("t1_busy",   32'(busy),      32'd0);
        chk("t1_wen",    32'(m.im_wen),  32'd0);
        chk("t1_count",  32'(count),     32'd3);
        chk("t1_err",    32'(err),       32'd0);

        // immediate formats, unused fields carry junk
        pulse_start();
        send(5'd10, 5'd5, 5'd0, 5'd7, 13'h1FFF, 1'b0);
        chk("addi_addr", 32'(m.im_addr), 32'd16);
        chk("addi_data", m.im_wdata,     32'hFFF0_0293);
        send(5'd19, 5'd4, 5'd2, 5'd0, 13'd8, 1'b0);
        chk("lw_data",   m.im_wdata,     32'h0081_2203);
        send(5'd20, 5'd9, 5'd2, 5'd6, 13'd12, 1'b0);
        chk("sw_data",   m.im_wdata,     32'h0061_2623);
        send(5'd21, 5'd5, 5'd1, 5'd2, 13'h1FF8, 1'b1);
        chk("beq_data",  m.im_wdata,     32'hFE20_8CE3);
        chk("beq_addr",  32'(m.im_addr), 32'd19);
        step();
        chk("t2_done",   32'(done),      32'd1);
        chk("t2_count",  32'(count),     32'd4);

        // illegal op_code mid-stream
        pulse_start();
        chk("t3_err0",   32'(err),       32'd0);
        send(5'd10, 5'd1, 5'd0, 5'd0, 13'd5, 1'b0);
        send(5'd25, 5'd3, 5'd1, 5'd2, 13'd0, 1'b0);
        chk("ill_data",  m.im_wdata,     32'h0000_0013);
        chk("ill_addr",  32'(m.im_addr), 32'd17);
        chk("ill_err",   32'(err),       32'd1);
        send(5'd0, 5'd3, 5'd1, 5'd2, 13'd0, 1'b0);
        chk("ill_next",  m.im_wdata,     32'h0020_81B3);
        chk("ill_naddr", 32'(m.im_addr), 32'd18);
        send(5'd19, 5'd4, 5'd2, 5'd0, 13'd8, 1'b1);
        step();
        chk("t3_done",   32'(done),      32'd1);
        chk("t3_err",    32'(err),       32'd1);
        pulse_start();
        chk("t3_errclr", 32'(err),       32'd0);
        chk("t3_cnt0",   32'(count),     32'd0);
        chk("t3_base",   32'(m.im_addr), 32'd16);

        // backpressure gaps with start held high during the session
        wa.delete();
        wd.delete();
        start = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            send(5'd10, 5'(i), 5'd0, 5'd0, 13'(i), 1'b0);
            chk("bp_wen",   32'(m.im_wen), 32'd1);
            step();
            chk("bp_gap",   32'(m.im_wen), 32'd0);
            chk("bp_busy",  32'(busy),     32'd1);
            chk("bp_count", 32'(count),    32'(i));
        end
        send(5'd10, 5'd5, 5'd0, 5'd0, 13'd5, 1'b1);
        start = 1'b0;
        step();
        chk("bp_done", 32'(done), 32'd1);
        m.in_valid = 1'b1;
        step();
        step();
        chk("bp_dn_ready", 32'(m.in_ready), 32'd0);
        m.in_valid = 1'b0;
        step();
        chk("bp_nwrites", 32'(wa.size()), 32'd5);
        for (int i = 0; i < wa.size() && i < 5; i++) begin
            chk("bp_addr", 32'(wa[i]), 32'(16 + i));
            chk("bp_data", wd[i],      addi_k[i+1]);
        end

        // overflow on the DEPTH=4 instance, base 6 wraps modulo 8
        s_start = 1'b1;
        step();
        s_start = 1'b0;
        acc = 0;
        k = 1;
        s.op_code = 5'd10; s.rd = 5'd1; s.imm = 13'd1; s.last = 1'b0; s.in_valid = 1'b1;
        for (int c = 0; c < 14; c++) begin
            rdy = s.in_ready;
            step();
            if (rdy === 1'b1) begin
                acc++;
                k++;
                s.rd  = 5'(k);
                s.imm = 13'(k);
                if (k > 6) s.in_valid = 1'b0;
            end
        end
        chk("ov_ready",   32'(s.in_ready),  32'd0);
        s.in_valid = 1'b0;
        chk("ov_accepts", 32'(acc),         32'd4);
        chk("ov_writes",  32'(sa.size()),   32'd4);
        chk("ov_done",    32'(s_done),      32'd1);
        chk("ov_err",     32'(s_err),       32'd1);
        chk("ov_count",   32'(s_count),     32'd4);
        chk("ov_busy",    32'(s_busy),      32'd0);
        if (sa.size() == 4) begin
            chk("ov_addr0", 32'(sa[0]), 32'd6);
            chk("ov_addr1", 32'(sa[1]), 32'd7);
            chk("ov_addr2", 32'(sa[2]), 32'd0);
            chk("ov_addr3", 32'(sa[3]), 32'd1);
            for (int i = 0; i < 4; i++) chk("ov_data", sd[i], addi_k[i+1]);
        end

        // reset during back-to-back writes
        pulse_start();
        send(5'd25, 5'd0, 5'd0, 5'd0, 13'd0, 1'b0);
        send(5'd0, 5'd3, 5'd1, 5'd2, 13'd0, 1'b0);
        chk("mr_wen_pre", 32'(m.im_wen), 32'd1);
        n0 = wa.size();
        m.op_code = 5'd1; m.in_valid = 1'b1;
        rst_n = 1'b0;
        step();
        chk("mr_wen",   32'(m.im_wen),   32'd0);
        chk("mr_busy",  32'(busy),       32'd0);
        chk("mr_count", 32'(count),      32'd0);
        chk("mr_err",   32'(err),        32'd0);
        chk("mr_addr",  32'(m.im_addr),  32'd0);
        chk("mr_ready", 32'(m.in_ready), 32'd0);
        rst_n = 1'b1;
        step();
        m.in_valid = 1'b0;
        chk("mr_idle_busy", 32'(busy),     32'd0);
        chk("mr_idle_done", 32'(done),     32'd0);
        chk("mr_idle_wen",  32'(m.im_wen), 32'd0);
        step();
        chk("mr_nwrites", 32'(wa.size()), 32'(n0 + 1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
